uart_tx: RTL

Serial transmitter for the UART peripheral. It accepts one byte per `uart_tx_en` pulse from `uart_ctl` and reports `uart_tx_busy` back to it. It shifts the byte out on `uart_txd` as an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It can also drive a line break, which is the counterpart of the receiver's `uart_rx_break` detection.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings, parity
// mode codes and the default bit period.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
  } uart_state_e;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  // 100 MHz / 115200 baud
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit clock divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count; held at zero when cleared or disabled.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == TERM);

  // next count: clear on request or when idle, wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2
// stop bits, plus a level-driven line break followed by one mark bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int PARITY       = UART_PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_break,
  output logic       uart_tx_busy,
  output logic       uart_tx_done,
  output logic       uart_txd
);

  localparam logic       PAR_EN    = (PARITY == UART_PARITY_EVEN) || (PARITY == UART_PARITY_ODD);
  localparam logic       PAR_ODD   = (PARITY == UART_PARITY_ODD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick_s;
  logic        cnt_clr_s;
  logic        cnt_en_s;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign cnt_en_s = (state_q != ST_IDLE) && (state_q != ST_BREAK);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .tick_o(tick_s)
  );

  // next-state, shift/index updates and registered-output decode
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uart_tx_break) begin
          state_d = ST_BREAK;
        end else if (uart_tx_en) begin
          data_d  = uart_tx_data;
          shift_d = uart_tx_data;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) state_d = ST_DATA;
        else        state_d = ST_START;
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) state_d = ST_STOP;
        else        state_d = ST_PARITY;
      end
      ST_STOP: begin
        if (tick_s) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (!uart_tx_break) state_d = ST_MARK;
        else                state_d = ST_BREAK;
      end
      ST_MARK: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_MARK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // every state entry restarts both the bit period and the bit index
    cnt_clr_s = (state_d != state_q);
    if (cnt_clr_s) begin
      bit_idx_d = 3'd0;
    end else begin
      bit_idx_d = bit_idx_d;
    end

    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = parity_bit(data_q, PAR_ODD);
      ST_STOP:   txd_d = 1'b1;
      ST_BREAK:  txd_d = 1'b0;
      ST_MARK:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;

endmodule
